// File: rtl/add_chain_sequencer.sv
// add_chain_sequencer
// Multi-byte add sequencer driving an external 8-bit combinational adder.
// Operands are accepted on a valid/ready handshake. The adder is then fed
// one byte per clock, least-significant byte first. Each byte's carry-out
// is chained into the next byte's carry-in.
// The assembled result is presented with cout/zero/ovf flags until the
// consumer takes it.
// Optional build macro: ADD_CHAIN_SUB_EN adds a sub_in port. When sub_in is
// set, the block computes A - B as A + ~B + 1.
module add_chain_sequencer #(
    parameter  int NUM_BYTES = 2,
    localparam int W         = 8 * NUM_BYTES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a_in,
    input  logic [W-1:0] b_in,
    input  logic         cin_in,
`ifdef ADD_CHAIN_SUB_EN
    input  logic         sub_in,
`endif
    output logic [7:0]   adder_a,
    output logic [7:0]   adder_b,
    output logic         adder_cin,
    input  logic [7:0]   adder_sum,
    input  logic         adder_cout,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         cout,
    output logic         zero,
    output logic         ovf
);

    localparam int IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg;
    logic [W-1:0]     a_reg;
    logic [W-1:0]     b_reg;          // holds B_eff (already inverted for subtract)
    logic             cin_reg;        // initial carry for byte 0
    logic             carry_reg;      // carry chained between bytes
    logic [IDX_W-1:0] idx_reg;
    logic [W-1:0]     result_reg;
    logic [W-1:0]     result_next;
    logic             in_ready_reg;
    logic             out_valid_reg;
    logic             cout_reg;
    logic             zero_reg;
    logic             ovf_reg;

    logic [W-1:0]     b_eff_in;
    logic             cin_eff_in;
    logic [7:0]       a_bytes [NUM_BYTES];
    logic [7:0]       b_bytes [NUM_BYTES];

`ifdef ADD_CHAIN_SUB_EN
    // Subtract is folded in at capture time: store ~B and force the initial carry.
    assign b_eff_in   = sub_in ? ~b_in : b_in;
    assign cin_eff_in = sub_in | cin_in;
`else
    assign b_eff_in   = b_in;
    assign cin_eff_in = cin_in;
`endif

    // Byte views of the operands.
    // result_next merges the current adder byte into the running result.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_BYTES; gi++) begin : g_bytes
            assign a_bytes[gi] = a_reg[8*gi +: 8];
            assign b_bytes[gi] = b_reg[8*gi +: 8];
            assign result_next[8*gi +: 8] =
                ((state_reg == RUN) && (idx_reg == IDX_W'(gi))) ? adder_sum
                                                                 : result_reg[8*gi +: 8];
        end
    endgenerate

    // Drive the external adder only while running; it sees zeros otherwise.
    always_comb begin
        adder_a   = 8'd0;
        adder_b   = 8'd0;
        adder_cin = 1'b0;
        if (state_reg == RUN) begin
            adder_a   = a_bytes[idx_reg];
            adder_b   = b_bytes[idx_reg];
            adder_cin = (idx_reg == '0) ? cin_reg : carry_reg;
        end
    end

    // Sequencer: capture operands, walk the bytes, hold the result until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            cin_reg       <= 1'b0;
            carry_reg     <= 1'b0;
            idx_reg       <= '0;
            result_reg    <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            cout_reg      <= 1'b0;
            zero_reg      <= 1'b0;
            ovf_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        a_reg        <= a_in;
                        b_reg        <= b_eff_in;
                        cin_reg      <= cin_eff_in;
                        carry_reg    <= 1'b0;
                        idx_reg      <= '0;
                        in_ready_reg <= 1'b0;
                        state_reg    <= RUN;
                    end
                end
                RUN: begin
                    result_reg <= result_next;
                    carry_reg  <= adder_cout;
                    if (idx_reg == LAST_IDX) begin
                        cout_reg      <= adder_cout;
                        ovf_reg       <= (adder_a[7] == adder_b[7]) && (adder_sum[7] != adder_a[7]);
                        zero_reg      <= (result_next == '0);
                        idx_reg       <= '0;
                        out_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end else begin
                        idx_reg <= idx_reg + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign result    = result_reg;
    assign cout      = cout_reg;
    assign zero      = zero_reg;
    assign ovf       = ovf_reg;

endmodule

// File: tb/tb_add_chain_sequencer.sv
// Testbench for add_chain_sequencer (NUM_BYTES=2).
// Stimulus pushes expected results into a queue; a negedge monitor pops and
// compares whenever a result is handed off (out_valid && out_ready).
module tb_add_chain_sequencer;

    localparam int NB = 2;
    localparam int W  = 8 * NB;

    typedef struct packed {
        logic [W-1:0] res;
        logic         co;
        logic         z;
        logic         o;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         cin_in;
    logic         sub_drive;
    logic [7:0]   adder_a;
    logic [7:0]   adder_b;
    logic         adder_cin;
    logic [7:0]   adder_sum;
    logic         adder_cout;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         cout;
    logic         zero;
    logic         ovf;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    logic cin_trace [0:15];
    int   last_lat;

    always #5 clk = ~clk;

    // Stand-in for the team's combinational 8-bit adder.
    assign {adder_cout, adder_sum} = {1'b0, adder_a} + {1'b0, adder_b} + {8'd0, adder_cin};

    add_chain_sequencer #(.NUM_BYTES(NB)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a_in       (a_in),
        .b_in       (b_in),
        .cin_in     (cin_in),
`ifdef ADD_CHAIN_SUB_EN
        .sub_in     (sub_drive),
`endif
        .adder_a    (adder_a),
        .adder_b    (adder_b),
        .adder_cin  (adder_cin),
        .adder_sum  (adder_sum),
        .adder_cout (adder_cout),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .cout       (cout),
        .zero       (zero),
        .ovf        (ovf)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: whole-word arithmetic on the operands.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic c, input logic s);
        exp_t         e;
        logic [W:0]   full;
        logic [W-1:0] be;
        logic         ci;
        be     = s ? ~b : b;
        ci     = s ? 1'b1 : c;
        full   = {1'b0, a} + {1'b0, be} + (W+1)'(ci);
        e.res  = full[W-1:0];
        e.co   = full[W];
        e.z    = (full[W-1:0] == '0);
        e.o    = (a[W-1] == be[W-1]) && (full[W-1] != a[W-1]);
        return e;
    endfunction

    // Monitor: each handed-off result is compared against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got %0h expected none", result);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("txn result=%h cout=%b zero=%b ovf=%b (exp %h %b %b %b)",
                         result, cout, zero, ovf, e.res, e.co, e.z, e.o);
                chk("result", {48'd0, result}, {48'd0, e.res});
                chk("cout", {63'd0, cout}, {63'd0, e.co});
                chk("zero", {63'd0, zero}, {63'd0, e.z});
                chk("ovf", {63'd0, ovf}, {63'd0, e.o});
            end
        end
    end

    // Present one operand set, then record the carry-in per RUN cycle and the latency.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, input logic s);
        int n;
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 64'd0, 64'd1);
        a_in      = a;
        b_in      = b;
        cin_in    = c;
        sub_drive = s;
        in_valid  = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        n = 0;
        forever begin
            @(negedge clk);
            if (out_valid || n >= 16) break;
            cin_trace[n] = adder_cin;
            n++;
        end
        last_lat = n;
        chk("latency", 64'(n), 64'(NB));
    endtask

    task automatic run_dir(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                           input logic s, input logic [W-1:0] r, input logic co,
                           input logic z, input logic o);
        exp_t e;
        e.res = r; e.co = co; e.z = z; e.o = o;
        exp_q.push_back(e);
        issue(a, b, c, s);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] hold_res;
        logic [2:0]   hold_flags;
        logic [W-1:0] ra, rb;
        logic         rc, rs;

        rst = 1'b1; in_valid = 1'b0; a_in = '0; b_in = '0; cin_in = 1'b0;
        sub_drive = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_result", {48'd0, result}, 64'd0);
        chk("rst_flags", {61'd0, cout, zero, ovf}, 64'd0);
        chk("rst_adder", {47'd0, adder_a, adder_b, adder_cin}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Carry chain, wrap and overflow vectors.
        run_dir(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
        chk("chain_cin_byte0", {63'd0, cin_trace[0]}, 64'd0);
        chk("chain_cin_byte1", {63'd0, cin_trace[1]}, 64'd1);
        run_dir(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        run_dir(16'hFFFE, 16'h0000, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        run_dir(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b1);
        run_dir(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
`ifdef ADD_CHAIN_SUB_EN
        run_dir(16'h1000, 16'h0001, 1'b0, 1'b1, 16'h0FFF, 1'b1, 1'b0, 1'b0);
        run_dir(16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
`endif

        // Backpressure: hold the result for 5 cycles while in_valid pulses.
        @(posedge clk);
        #1 out_ready = 1'b0;
        run_dir(16'h1357, 16'h2468, 1'b0, 1'b0, 16'h37BF, 1'b0, 1'b0, 1'b0);
        hold_res   = result;
        hold_flags = {cout, zero, ovf};
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            a_in     = 16'($urandom);
            b_in     = 16'($urandom);
            in_valid = 1'b1;
            @(negedge clk);
            chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
            chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
            chk("bp_result", {48'd0, result}, {48'd0, hold_res});
            chk("bp_flags", {61'd0, cout, zero, ovf}, {61'd0, hold_flags});
            in_valid = 1'b0;
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_valid", {63'd0, out_valid}, 64'd0);
        chk("bp_release_ready", {63'd0, in_ready}, 64'd1);
        run_dir(16'h0102, 16'h0304, 1'b1, 1'b0, 16'h0407, 1'b0, 1'b0, 1'b0);

        // Reset during the first RUN cycle discards the operation.
        @(negedge clk);
        a_in = 16'hAAAA; b_in = 16'h5555; cin_in = 1'b0; sub_drive = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_result", {48'd0, result}, 64'd0);
        chk("midrst_adder", {47'd0, adder_a, adder_b, adder_cin}, 64'd0);
        run_dir(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0);

        // Random operations against the reference model.
        for (int i = 0; i < 30; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (i % 5 == 0) rb = -ra;
            rc = 1'($urandom);
`ifdef ADD_CHAIN_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            exp_q.push_back(model(ra, rb, rc, rs));
            issue(ra, rb, rc, rs);
        end

        repeat (5) @(negedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
